pic_priority_core: RTL and testbench
====================================

PIC_PRIORITY_CORE -- requirements
Module: pic_priority_core

Interface
REQ-001 Parameter NUM_IRQ, default 8, sets the number of interrupt channels (2..32).
REQ-002 Parameter ID_W, default $clog2(NUM_IRQ), sets the width of the channel id.
REQ-003 Parameter AEOI, default 0; when 1, the ISR bit clears automatically at the end of acknowledge.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 irq_in  input  NUM_IRQ  raw interrupt request lines.
REQ-007 level_mode  input  1  1 = level-triggered, 0 = rising-edge-triggered.
REQ-008 imr  input  NUM_IRQ  mask; bit = 1 blocks that channel.
REQ-009 rotate_en  input  1  automatic rotation on EOI.
REQ-010 eoi_valid / eoi_specific / eoi_id  input  1/1/ID_W  end-of-interrupt command; one-cycle pulse.
REQ-011 setp_valid / setp_id  input  1/ID_W  specific rotation; setp_id becomes the lowest priority.
REQ-012 inta  input  1  acknowledge strobe; one cycle high per pulse.
REQ-013 int_out  output  1  interrupt request to the CPU.
REQ-014 vec_valid / vec_id  output  1/ID_W  acknowledged channel id; one-cycle strobe.
REQ-015 irr_out / isr_out / hp_out  output  NUM_IRQ/NUM_IRQ/ID_W  register visibility: IRR, ISR, highest-priority pointer.

Function
REQ-016 Edge mode SHALL set IRR[i] when irq_in[i] is 1 and was 0 in the previous cycle; level mode SHALL set IRR[i] while irq_in[i]=1 and clear it when irq_in[i]=0.
REQ-017 Rotating priority SHALL start at channel hp and ascend with wrap modulo NUM_IRQ; hp resets to 0.
REQ-018 The winner SHALL be the first set bit of IRR & ~imr in rotating order.
REQ-019 A request SHALL be valid only when the winner ranks strictly above the highest-ranked ISR bit, or when ISR is empty (fully nested).
REQ-020 int_out SHALL be registered: asserted 1 cycle after a valid request exists, in IDLE or PEND only.
REQ-021 FSM states SHALL be IDLE, PEND, ACK1.
- IDLE->PEND: valid request.
- PEND->IDLE: request lost.
- PEND->ACK1: inta.
- ACK1->IDLE: inta.
REQ-022 On the first inta, the core SHALL latch the winner id, set ISR[id], clear IRR[id] (edge mode) and deassert int_out the next cycle.
REQ-023 On the second inta, the core SHALL pulse vec_valid for 1 cycle with the latched id; with AEOI=1 it SHALL clear ISR[id] and rotate when rotate_en is set.
REQ-024 If no valid winner exists at the first inta, the core SHALL latch the spurious id NUM_IRQ-1 and leave ISR unchanged.
REQ-025 Non-specific EOI SHALL clear the highest-ranked ISR bit; specific EOI SHALL clear ISR[eoi_id]; EOI with the target bit already clear SHALL have no effect.
REQ-026 When rotate_en is set and an EOI clears bit k, hp SHALL become (k+1) mod NUM_IRQ; setp_valid SHALL set hp to (setp_id+1) mod NUM_IRQ.
REQ-027 EOI in the same cycle as the first inta: the EOI clear applies first, then the ISR set; setp_valid and an EOI rotation together: setp_valid wins.
REQ-028 An inta in IDLE SHALL be ignored; a new edge on a channel whose IRR bit is already set SHALL be absorbed.

Reset
REQ-029 rst_n low SHALL immediately clear IRR, ISR, hp, the edge history, int_out, vec_valid and vec_id, and put the FSM in IDLE, including mid-acknowledge.
REQ-030 After rst_n rises, a line held high SHALL not count as an edge until it has been seen low.

Structure
REQ-031 Package pic_pkg SHALL hold the FSM state enum, the NUM_IRQ default and a function computing the spurious id.
REQ-032 Sub-module rotating_prio_encoder (NUM_IRQ-wide, combinational, inputs: vector and hp; outputs: found and id) SHALL be instantiated twice: once for IRR winner selection, once for ISR highest-rank selection.

Verification
REQ-033 Edge mode, hp=0, IRQ3 and IRQ5 pulse together -> int_out; inta×2 -> vec_id=3, isr_out=0x08; then vec_id=5 only after a non-specific EOI.
REQ-034 IRQ5 in service, IRQ2 rises -> int_out reasserts (nesting); IRQ6 rises instead -> int_out stays 0.
REQ-035 rotate_en=1, EOI clears ISR bit 4 -> hp_out=5; with IRQ4 and IRQ6 pending, IRQ6 wins.
REQ-036 Level mode: IRQ1 drops after int_out but before the first inta -> vec_id=7, isr_out unchanged.
REQ-037 AEOI=1, NUM_IRQ=16, IRQ12 -> vec_valid with vec_id=12 and isr_out=0 the following cycle.
REQ-038 rst_n pulsed low between the two inta pulses -> outputs zero, FSM IDLE, no vec_valid.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the priority interrupt controller core.
// FSM encoding, default channel count and spurious id.
package pic_pkg;

  localparam int NUM_IRQ_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK1 = 2'd2
  } pic_state_e;

  // The spurious vector is always the last channel
  function automatic int spurious_id(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/rotating_prio_encoder.sv
// Finds the first set bit of vec, scanning upward from hp with wrap.
// Purely combinational; id is 0 when nothing is found.
module rotating_prio_encoder #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec,
  input  logic [ID_W-1:0]    hp,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  int idx;

  // Scan from the far end so the closest hit to hp is written last
  always_comb begin
    found = 1'b0;
    id    = '0;
    idx   = 0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = (int'(hp) + k) % NUM_IRQ;
      if (vec[idx]) begin
        found = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pic_priority_core.sv
// Rotating, fully nested priority interrupt controller core.
// Two-pulse acknowledge, EOI handling and optional auto-EOI.
module pic_priority_core
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int AEOI    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               level_mode,
  input  logic [NUM_IRQ-1:0] imr,
  input  logic               rotate_en,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_id,
  input  logic               setp_valid,
  input  logic [ID_W-1:0]    setp_id,
  input  logic               inta,
  output logic               int_out,
  output logic               vec_valid,
  output logic [ID_W-1:0]    vec_id,
  output logic [NUM_IRQ-1:0] irr_out,
  output logic [NUM_IRQ-1:0] isr_out,
  output logic [ID_W-1:0]    hp_out
);

  localparam logic [ID_W-1:0] SPUR_ID = ID_W'(spurious_id(NUM_IRQ));

  pic_state_e state, state_d;

  logic [NUM_IRQ-1:0] irr, irr_d, irr_clr;
  logic [NUM_IRQ-1:0] isr, isr_d;
  logic [NUM_IRQ-1:0] irq_prev;
  logic [NUM_IRQ-1:0] edge_set;
  logic [ID_W-1:0]    hp, hp_d;
  logic [ID_W-1:0]    lat_id;
  logic               lat_spur;

  logic               win_found, top_found;
  logic [ID_W-1:0]    win_id, top_id;
  logic               req_ok;
  logic               ack1, ack2;
  logic               int_d;
  logic               eoi_hit;
  logic [ID_W-1:0]    eoi_tgt;

  function automatic int rank_of(input logic [ID_W-1:0] ch,
                                 input logic [ID_W-1:0] base);
    return (int'(ch) - int'(base) + NUM_IRQ) % NUM_IRQ;
  endfunction

  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] k);
    return ID_W'((int'(k) + 1) % NUM_IRQ);
  endfunction

  rotating_prio_encoder #(
    .NUM_IRQ(NUM_IRQ),
    .ID_W   (ID_W)
  ) u_win (
    .vec  (irr & ~imr),
    .hp   (hp),
    .found(win_found),
    .id   (win_id)
  );

  rotating_prio_encoder #(
    .NUM_IRQ(NUM_IRQ),
    .ID_W   (ID_W)
  ) u_top (
    .vec  (isr),
    .hp   (hp),
    .found(top_found),
    .id   (top_id)
  );

  // Fully nested: only a strictly higher rank may interrupt service
  assign req_ok = win_found &&
    (!top_found || rank_of(win_id, hp) < rank_of(top_id, hp));

  always_comb begin
    state_d = state;
    ack1    = 1'b0;
    ack2    = 1'b0;
    unique case (state)
      IDLE: if (req_ok) state_d = PEND;
      PEND: begin
        if (inta) begin
          state_d = ACK1;
          ack1    = 1'b1;
        end else if (!req_ok) begin
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (inta) begin
          state_d = IDLE;
          ack2    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    edge_set = level_mode ? '0 : (irq_in & ~irq_prev);
    eoi_tgt  = eoi_specific ? eoi_id : top_id;
    eoi_hit  = 1'b0;
    unique case (1'b1)
      !eoi_valid:   eoi_hit = 1'b0;
      eoi_specific: eoi_hit = (int'(eoi_id) < NUM_IRQ) && isr[eoi_id];
      default:      eoi_hit = top_found;
    endcase

    isr_d = isr;
    hp_d  = hp;
    if (eoi_hit) begin
      isr_d[eoi_tgt] = 1'b0;
      if (rotate_en) hp_d = nxt(eoi_tgt);
    end
    if (ack2 && AEOI != 0 && !lat_spur) begin
      isr_d[lat_id] = 1'b0;
      if (rotate_en) hp_d = nxt(lat_id);
    end
    if (ack1 && req_ok) isr_d[win_id] = 1'b1;
    if (setp_valid) hp_d = nxt(setp_id);

    irr_clr = '0;
    if (ack1 && req_ok && !level_mode) irr_clr[win_id] = 1'b1;
    irr_d = level_mode ? irq_in : ((irr & ~irr_clr) | edge_set);

    int_d = req_ok && (state == IDLE || (state == PEND && !inta));
  end

  // Edge history resets high so a line held through reset needs a low first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      irr       <= '0;
      isr       <= '0;
      hp        <= '0;
      irq_prev  <= '1;
      int_out   <= 1'b0;
      vec_valid <= 1'b0;
      vec_id    <= '0;
      lat_id    <= '0;
      lat_spur  <= 1'b0;
    end else begin
      state     <= state_d;
      irr       <= irr_d;
      isr       <= isr_d;
      hp        <= hp_d;
      irq_prev  <= irq_in;
      int_out   <= int_d;
      vec_valid <= ack2;
      if (ack1) begin
        lat_id   <= req_ok ? win_id : SPUR_ID;
        lat_spur <= !req_ok;
      end
      if (ack2) vec_id <= lat_id;
    end
  end

  assign irr_out = irr;
  assign isr_out = isr;
  assign hp_out  = hp;

endmodule

// File: tb/tb_pic_priority_core.sv
// Directed bench for pic_priority_core: nesting, rotation, spurious,
// auto-EOI and reset during acknowledge.
module tb_pic_priority_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in, imr;
  logic       level_mode, rotate_en;
  logic       eoi_valid, eoi_specific, setp_valid, inta;
  logic [2:0] eoi_id, setp_id;
  logic       int_out, vec_valid;
  logic [2:0] vec_id, hp_out;
  logic [7:0] irr_out, isr_out;

  logic [15:0] irq16, irr16, isr16;
  logic        inta16, int16, vv16;
  logic [3:0]  vid16, hp16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pic_priority_core #(.NUM_IRQ(8), .AEOI(0)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
    .level_mode(level_mode), .imr(imr), .rotate_en(rotate_en),
    .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_id(eoi_id), .setp_valid(setp_valid), .setp_id(setp_id),
    .inta(inta), .int_out(int_out), .vec_valid(vec_valid),
    .vec_id(vec_id), .irr_out(irr_out), .isr_out(isr_out),
    .hp_out(hp_out)
  );

  pic_priority_core #(.NUM_IRQ(16), .AEOI(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .irq_in(irq16),
    .level_mode(1'b0), .imr(16'h0000), .rotate_en(1'b0),
    .eoi_valid(1'b0), .eoi_specific(1'b0), .eoi_id(4'd0),
    .setp_valid(1'b0), .setp_id(4'd0), .inta(inta16),
    .int_out(int16), .vec_valid(vv16), .vec_id(vid16),
    .irr_out(irr16), .isr_out(isr16), .hp_out(hp16)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] m);
    irq_in = m;
    step(1);
    irq_in = 8'h00;
  endtask

  task automatic ack();
    inta = 1'b1; step(1);
    inta = 1'b0; step(1);
    inta = 1'b1; step(1);
    inta = 1'b0;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] id);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_id = id;
    step(1);
    eoi_valid = 1'b0; eoi_specific = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 8'h01; imr = 8'h00;
    level_mode = 1'b0; rotate_en = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_id = 3'd0;
    setp_valid = 1'b0; setp_id = 3'd0; inta = 1'b0;
    irq16 = 16'h0000; inta16 = 1'b0;

    step(2);
    chk("rst_int", 32'(int_out), 0);
    chk("rst_irr", 32'(irr_out), 0);
    chk("rst_isr", 32'(isr_out), 0);
    chk("rst_hp", 32'(hp_out), 0);
    chk("rst_vv", 32'(vec_valid), 0);
    rst_n = 1'b1;
    step(3);
    chk("held_high_no_edge", 32'(irr_out), 0);
    irq_in = 8'h00;
    step(2);
    chk("held_low_no_edge", 32'(irr_out), 0);

    // IRQ3 + IRQ5 together
    pulse(8'h28);
    chk("irr_3_5", 32'(irr_out), 'h28);
    step(1);
    chk("int_3_5", 32'(int_out), 1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("int_drop_ack1", 32'(int_out), 0);
    chk("isr_3", 32'(isr_out), 'h08);
    chk("irr_left_5", 32'(irr_out), 'h20);
    step(1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("vv_3", 32'(vec_valid), 1);
    chk("vid_3", 32'(vec_id), 3);
    step(2);
    chk("vv_pulse", 32'(vec_valid), 0);
    chk("5_blocked", 32'(int_out), 0);
    eoi(1'b0, 3'd0);
    chk("eoi_isr3", 32'(isr_out), 0);
    step(1);
    chk("int_5", 32'(int_out), 1);
    ack();
    chk("vid_5", 32'(vec_id), 5);
    chk("isr_5", 32'(isr_out), 'h20);

    // Nesting: IRQ2 preempts IRQ5, IRQ6 does not
    pulse(8'h04);
    step(1);
    chk("nest_2", 32'(int_out), 1);
    ack();
    chk("vid_2", 32'(vec_id), 2);
    chk("isr_2_5", 32'(isr_out), 'h24);
    eoi(1'b0, 3'd0);
    chk("eoi_top_2", 32'(isr_out), 'h20);
    pulse(8'h40);
    step(2);
    chk("no_nest_6", 32'(int_out), 0);
    chk("irr_6", 32'(irr_out), 'h40);
    eoi(1'b0, 3'd0);
    chk("eoi_5", 32'(isr_out), 0);
    step(1);
    chk("int_6", 32'(int_out), 1);
    ack();
    chk("vid_6", 32'(vec_id), 6);
    eoi(1'b1, 3'd6);
    chk("spec_eoi_6", 32'(isr_out), 0);

    // Rotation
    rotate_en = 1'b1;
    pulse(8'h10);
    step(1);
    ack();
    chk("vid_4", 32'(vec_id), 4);
    pulse(8'h50);
    chk("irr_4_6", 32'(irr_out), 'h50);
    step(1);
    chk("4_6_blocked", 32'(int_out), 0);
    eoi(1'b1, 3'd3);
    chk("eoi_clear_hp", 32'(hp_out), 0);
    chk("eoi_clear_isr", 32'(isr_out), 'h10);
    eoi(1'b0, 3'd0);
    chk("rot_hp5", 32'(hp_out), 5);
    step(1);
    chk("int_rot", 32'(int_out), 1);
    ack();
    chk("rot_vid6", 32'(vec_id), 6);
    eoi_valid = 1'b1; setp_valid = 1'b1; setp_id = 3'd1;
    step(1);
    eoi_valid = 1'b0; setp_valid = 1'b0;
    chk("setp_wins", 32'(hp_out), 2);
    chk("setp_eoi_isr", 32'(isr_out), 0);
    rotate_en = 1'b0;
    step(1);
    ack();
    chk("vid_4b", 32'(vec_id), 4);
    eoi(1'b0, 3'd0);
    setp_valid = 1'b1; setp_id = 3'd7;
    step(1);
    setp_valid = 1'b0;
    chk("setp_wrap", 32'(hp_out), 0);

    // Level mode: request vanishes before the first inta
    level_mode = 1'b1;
    irq_in = 8'h02;
    step(1);
    chk("lvl_irr", 32'(irr_out), 'h02);
    step(1);
    chk("lvl_int", 32'(int_out), 1);
    irq_in = 8'h00;
    step(1);
    chk("lvl_irr_drop", 32'(irr_out), 0);
    ack();
    chk("spur_vid", 32'(vec_id), 7);
    chk("spur_vv", 32'(vec_valid), 1);
    chk("spur_isr", 32'(isr_out), 0);
    level_mode = 1'b0;
    step(1);

    // Auto-EOI on the 16-channel instance
    irq16 = 16'h1000;
    step(1);
    irq16 = 16'h0000;
    step(1);
    chk("a_int", 32'(int16), 1);
    inta16 = 1'b1; step(1); inta16 = 1'b0;
    chk("a_isr12", 32'(isr16), 'h1000);
    step(1);
    inta16 = 1'b1; step(1); inta16 = 1'b0;
    chk("a_vv", 32'(vv16), 1);
    chk("a_vid12", 32'(vid16), 12);
    chk("a_isr0", 32'(isr16), 0);

    // Reset between the two inta pulses
    pulse(8'h02);
    step(1);
    chk("r_int", 32'(int_out), 1);
    inta = 1'b1; step(1); inta = 1'b0;
    chk("r_isr1", 32'(isr_out), 'h02);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("r_async_isr", 32'(isr_out), 0);
    chk("r_async_int", 32'(int_out), 0);
    chk("r_async_irr", 32'(irr_out), 0);
    step(1);
    rst_n = 1'b1;
    inta = 1'b1;
    step(1);
    inta = 1'b0;
    chk("r_no_vv", 32'(vec_valid), 0);
    step(1);
    chk("r_no_vv2", 32'(vec_valid), 0);
    chk("r_vid0", 32'(vec_id), 0);
    chk("r_idle_int", 32'(int_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
